// File: rtl/serial_peer_uart.sv
// Full-duplex 8N1 UART endpoint with 16x oversampling and small RX/TX FIFOs.
// Models the far-end keyboard/MIDI device attached to the ACIA serial line.
module serial_peer_uart #(
    parameter int CLK_DIV = 64,
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_full,
    output logic       tx_busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PW    = FIFO_AW + 1;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [0:0] TX_IDLE  = 1'b0;
    localparam logic [0:0] TX_SHIFT = 1'b1;

    logic [DW-1:0] div;
    logic          tick;

    assign tick = (div == DW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset)     div <= '0;
        else if (tick) div <= '0;
        else           div <= div + DW'(1);
    end

    logic       sync1, sync2, filt;
    logic [1:0] hist;

    // Filtered level follows only after three equal synchronized samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 2'b11;
            filt  <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            hist  <= {hist[0], sync2};
            if (hist == {2{sync2}}) filt <= sync2;
        end
    end

    logic [1:0]    rx_state;
    logic [3:0]    rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] rx_wp, rx_rp;
    logic          rx_empty, rx_full, rx_push, rx_pop, stop_hit;

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                      (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);
    assign stop_hit = tick && (rx_state == RX_STOP) && (rx_cnt == 4'd0);
    assign rx_push  = stop_hit && filt && !rx_full;
    assign rx_pop   = rx_ack && !rx_empty;
    assign rx_valid = !rx_empty;
    assign rx_data  = rx_valid ? rx_mem[rx_rp[FIFO_AW-1:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else if (tick) begin
            case (rx_state)
                RX_IDLE: begin
                    if (!filt) begin
                        rx_state <= RX_START;
                        rx_cnt   <= 4'd7;
                    end
                end
                RX_START: begin
                    if (rx_cnt != 4'd0) begin
                        rx_cnt <= rx_cnt - 4'd1;
                    end else if (!filt) begin
                        rx_state <= RX_DATA;
                        rx_cnt   <= 4'd15;
                        rx_bit   <= '0;
                    end else begin
                        rx_state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt != 4'd0) begin
                        rx_cnt <= rx_cnt - 4'd1;
                    end else begin
                        rx_sh  <= {filt, rx_sh[7:1]};
                        rx_cnt <= 4'd15;
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt != 4'd0) rx_cnt <= rx_cnt - 4'd1;
                    else                rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // A drop on a full FIFO wins over a same-cycle pop clearing overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            if (rx_pop) rx_overrun <= 1'b0;
            if (stop_hit) begin
                if (filt) begin
                    rx_frame_err <= 1'b0;
                    if (rx_full) rx_overrun <= 1'b1;
                end else begin
                    rx_frame_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + PW'(1);
            if (rx_pop)  rx_rp <= rx_rp + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_sh;
    end

    logic [0:0]    tx_state;
    logic [3:0]    tx_cnt;
    logic [3:0]    tx_bit;
    logic [9:0]    tx_sh;
    logic [7:0]    tx_mem [DEPTH];
    logic [PW-1:0] tx_wp, tx_rp;
    logic          tx_empty, tx_push, tx_pop, tx_last;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                      (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
    assign tx_push  = tx_wr && !tx_full;
    assign tx_last  = (tx_state == TX_SHIFT) && (tx_cnt == 4'd0) &&
                      (tx_bit == 4'd9);
    // Reloading straight out of the stop bit keeps frames back-to-back.
    assign tx_pop   = tick && !tx_empty &&
                      ((tx_state == TX_IDLE) || tx_last);
    assign tx_busy  = !tx_empty || (tx_state == TX_SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_sh    <= '1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else if (tick) begin
            if (tx_pop) begin
                tx_sh    <= {1'b1, tx_mem[tx_rp[FIFO_AW-1:0]], 1'b0};
                tx_bit   <= '0;
                tx_cnt   <= 4'd15;
                tx_state <= TX_SHIFT;
            end else if (tx_state == TX_SHIFT) begin
                if (tx_cnt != 4'd0) begin
                    tx_cnt <= tx_cnt - 4'd1;
                end else if (tx_bit == 4'd9) begin
                    tx_state <= TX_IDLE;
                end else begin
                    tx_sh  <= {1'b1, tx_sh[9:1]};
                    tx_bit <= tx_bit + 4'd1;
                    tx_cnt <= 4'd15;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) tx <= 1'b1;
        else       tx <= (tx_state == TX_SHIFT) ? tx_sh[0] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PW'(1);
            if (tx_pop)  tx_rp <= tx_rp + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= tx_data;
    end

endmodule
